// File: rtl/vscale_pc_gen_if.sv
// vscale_pc_gen_pkg: PC select encodings and widths shared by the PC generator and its users.
// vscale_pc_gen_if: groups the control/operand inputs and the fetch-address outputs of the PC generator.
//   master modport: pipeline control side (drives select, operands and stall; observes PCs and flags).
//   slave modport : the PC generator itself.

package vscale_pc_gen_pkg;
    localparam int PC_SRC_SEL_WIDTH = 3;
    localparam int INST_WIDTH       = 32;

    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_PLUS4         = 3'd0;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_BRANCH_TARGET = 3'd1;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_JAL_TARGET    = 3'd2;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_JALR_TARGET   = 3'd3;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_REPLAY        = 3'd4;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_HANDLER       = 3'd5;
    localparam logic [PC_SRC_SEL_WIDTH-1:0] PC_EPC           = 3'd6;
endpackage

interface vscale_pc_gen_if #(
    parameter int XPR_LEN = 32
) ();
    logic [vscale_pc_gen_pkg::PC_SRC_SEL_WIDTH-1:0] PC_src_sel;
    logic [vscale_pc_gen_pkg::INST_WIDTH-1:0]       inst_DX;
    logic [XPR_LEN-1:0]                             rs1_data;
    logic [XPR_LEN-1:0]                             PC_DX;
    logic [XPR_LEN-1:0]                             handler_PC;
    logic [XPR_LEN-1:0]                             epc;
    logic                                           stall_IF;

    logic [XPR_LEN-1:0]                             PC_PIF;
    logic [XPR_LEN-1:0]                             PC_IF;
    logic                                           redirect_pending;
    logic                                           misaligned_fetch;
    logic [XPR_LEN-1:0]                             bad_fetch_addr;

    modport master (
        output PC_src_sel, inst_DX, rs1_data, PC_DX,
        output handler_PC, epc, stall_IF,
        input  PC_PIF, PC_IF, redirect_pending,
        input  misaligned_fetch, bad_fetch_addr
    );

    modport slave (
        input  PC_src_sel, inst_DX, rs1_data, PC_DX,
        input  handler_PC, epc, stall_IF,
        output PC_PIF, PC_IF, redirect_pending,
        output misaligned_fetch, bad_fetch_addr
    );
endinterface

// File: rtl/vscale_pc_gen.sv
// vscale_pc_gen: next-PC generator for the fetch stage; owns PC_IF, holds redirects across
// fetch stalls and flags misaligned jump/branch targets. Ports: clk, reset (sync, active-high), bus (slave).

module vscale_pc_gen #(
    parameter int          XPR_LEN        = 32,
    parameter logic [31:0] RESET_PC       = 32'h200,
    parameter int          FETCH_BYTES    = 4,
    parameter int          ALIGN_LOG2     = 2,
    parameter bit          MISALIGN_CHECK = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    vscale_pc_gen_if.slave   bus
);
    import vscale_pc_gen_pkg::*;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [XPR_LEN-1:0] LOW_MASK =
        XPR_LEN'((64'd1 << ALIGN_LOG2) - 64'd1);
    localparam logic [XPR_LEN-1:0] RST_PC = XPR_LEN'(RESET_PC);
    localparam logic [XPR_LEN-1:0] STEP   = XPR_LEN'(FETCH_BYTES);

    state_t             state_q, state_d;
    logic [XPR_LEN-1:0] pend_pc_q, pend_pc_d;
    logic [XPR_LEN-1:0] pc_if_q, pc_if_d;
    logic               mis_q;
    logic [XPR_LEN-1:0] bad_q;

    logic [31:0]        imm_j, imm_b, imm_i;
    logic [XPR_LEN-1:0] tgt, seq_pc, pc_pif;
    logic               redir, checked, misal;

    // Opcode bits carry no immediate information.
    logic unused_inst;
    assign unused_inst = ^bus.inst_DX[6:0];

    always_comb begin
        imm_j = {{12{bus.inst_DX[31]}}, bus.inst_DX[19:12],
                 bus.inst_DX[20], bus.inst_DX[30:21], 1'b0};
        imm_b = {{20{bus.inst_DX[31]}}, bus.inst_DX[7],
                 bus.inst_DX[30:25], bus.inst_DX[11:8], 1'b0};
        imm_i = {{20{bus.inst_DX[31]}}, bus.inst_DX[31:20]};
    end

    always_comb begin
        tgt     = '0;
        redir   = 1'b0;
        checked = 1'b0;
        seq_pc  = pc_if_q + STEP;
        case (bus.PC_src_sel)
            PC_JAL_TARGET: begin
                tgt     = bus.PC_DX + XPR_LEN'($signed(imm_j));
                redir   = 1'b1;
                checked = 1'b1;
            end
            PC_BRANCH_TARGET: begin
                tgt     = bus.PC_DX + XPR_LEN'($signed(imm_b));
                redir   = 1'b1;
                checked = 1'b1;
            end
            PC_JALR_TARGET: begin
                tgt     = (bus.rs1_data + XPR_LEN'($signed(imm_i)))
                          & ~XPR_LEN'(1);
                redir   = 1'b1;
                checked = 1'b1;
            end
            PC_HANDLER: begin
                tgt   = bus.handler_PC & ~LOW_MASK;
                redir = 1'b1;
            end
            PC_EPC: begin
                tgt   = bus.epc & ~LOW_MASK;
                redir = 1'b1;
            end
            PC_REPLAY: seq_pc = pc_if_q;
            default:   seq_pc = pc_if_q + STEP;
        endcase
        misal = MISALIGN_CHECK && checked && ((tgt & LOW_MASK) != '0);
    end

    // Priority: reset, trap on misaligned target, capture under stall,
    // live redirect, release of held redirect, stall, sequential.
    always_comb begin
        pc_pif    = pc_if_q;
        pc_if_d   = pc_if_q;
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        if (reset) begin
            pc_pif = RST_PC;
        end else if (misal) begin
            pc_pif = pc_if_q;
        end else if (redir && bus.stall_IF) begin
            state_d   = HOLD;
            pend_pc_d = tgt;
        end else if (redir) begin
            pc_pif  = tgt;
            pc_if_d = tgt;
            state_d = RUN;
        end else if (state_q == HOLD && !bus.stall_IF) begin
            pc_pif  = pend_pc_q;
            pc_if_d = pend_pc_q;
            state_d = RUN;
        end else if (bus.stall_IF) begin
            pc_pif = pc_if_q;
        end else begin
            pc_pif  = seq_pc;
            pc_if_d = seq_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
            pc_if_q   <= RST_PC;
            mis_q     <= 1'b0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            pc_if_q   <= pc_if_d;
            mis_q     <= misal;
            if (misal) begin
                bad_q <= tgt;
            end
        end
    end

    assign bus.PC_PIF           = pc_pif;
    assign bus.PC_IF            = pc_if_q;
    assign bus.redirect_pending = (state_q == HOLD);
    assign bus.misaligned_fetch = mis_q;
    assign bus.bad_fetch_addr   = bad_q;

endmodule

// File: doc/vscale_pc_gen.md
# vscale_pc_gen

Parametrised next-PC generator for the vscale fetch stage. It owns the PC_IF register and computes the fetch address PC_PIF from the control select and the DX-stage operands. Unlike a purely combinational PC mux, it holds redirects that arrive during a fetch stall and applies them when the stall releases. It also detects misaligned targets and reports them through a registered flag, so there is no combinational loop into the control logic. It sits between the pipeline control (PC_src_sel, stall_IF) and the instruction memory request port.

## Interface
- XPR_LEN, 32, datapath/address width.
- RESET_PC, 32'h200, PC_IF value after reset.
- FETCH_BYTES, 4, sequential increment in bytes (power of two, 2 or 4).
- ALIGN_LOG2, 2, target alignment checked: a target is misaligned when target[ALIGN_LOG2-1:0] != 0.
- MISALIGN_CHECK, 1, 1 = check and trap misaligned targets; 0 = never flag.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- PC_src_sel  in  `PC_SRC_SEL_WIDTH  `PC_PLUS4/`PC_JAL_TARGET/`PC_JALR_TARGET/`PC_BRANCH_TARGET/`PC_REPLAY/`PC_HANDLER/`PC_EPC.
- inst_DX  in  `INST_WIDTH  DX instruction for B/J/I immediates.
- rs1_data  in  XPR_LEN  JALR base.
- PC_DX  in  XPR_LEN  PC of DX instruction.
- handler_PC  in  XPR_LEN  trap vector.
- epc  in  XPR_LEN  exception return PC.
- stall_IF  in  1  fetch stage stalled; PC_IF must not advance.
- PC_PIF  out  XPR_LEN  combinational fetch address this cycle.
- PC_IF  out  XPR_LEN  registered PC of instruction in IF.
- redirect_pending  out  1  registered; a held redirect awaits stall release.
- misaligned_fetch  out  1  registered one-cycle pulse.
- bad_fetch_addr  out  XPR_LEN  registered offending target.

## Operation
- Target computation, XPR_LEN-bit arithmetic with wrap-around and carry discarded:
  - JAL: PC_DX + J-imm.
  - BRANCH: PC_DX + B-imm.
  - JALR: (rs1_data + sign-extended I-imm) with bit 0 cleared.
  - HANDLER: handler_PC with bits [ALIGN_LOG2-1:0] forced to 0.
  - EPC: epc with bits [ALIGN_LOG2-1:0] forced to 0.
  - PLUS4: PC_IF + FETCH_BYTES.
  - REPLAY: PC_IF.
  - Any other select encoding behaves as PLUS4.
- Redirect = JAL, JALR, BRANCH, HANDLER or EPC. Only JAL, JALR and BRANCH are alignment-checked; the check applies only when MISALIGN_CHECK=1.
- State: pend_valid, pend_pc. The two states are RUN (pend_valid=0) and HOLD (pend_valid=1).
- Next-address priority, per cycle:
  1. A misaligned checked redirect is not taken. PC_PIF = PC_IF and PC_IF holds. misaligned_fetch is asserted the next cycle and bad_fetch_addr latches the target. pend state is unchanged. This applies even when stall_IF=1.
  2. A valid redirect with stall_IF=1 goes to HOLD: pend_pc <= target. A newer redirect overwrites an older pend_pc (latest wins). PC_PIF = PC_IF.
  3. A valid redirect with stall_IF=0: PC_PIF = target, PC_IF <= target, pend cleared. This is true even if HOLD was active, because the new redirect supersedes the held one.
  4. HOLD with no redirect and stall_IF=0: PC_PIF = pend_pc, PC_IF <= pend_pc, return to RUN.
  5. No redirect and stall_IF=1: PC_PIF = PC_IF, PC_IF holds.
  6. Otherwise: PC_PIF = PLUS4/REPLAY value, PC_IF <= PC_PIF.
- bad_fetch_addr holds its value until the next misalignment.

## Timing
- Reset values: PC_IF=RESET_PC, pend_valid=0, pend_pc=0, misaligned_fetch=0, bad_fetch_addr=0, redirect_pending=0.
- While reset=1, PC_PIF = RESET_PC. Reset asserted mid-HOLD discards the held redirect.
- PC_PIF is combinational from inputs and state with zero latency. PC_IF reflects PC_PIF one cycle later, unless stalled.
- misaligned_fetch is high for exactly one cycle, the cycle after the offending select. Back-to-back misaligned selects give back-to-back pulses.
- redirect_pending = pend_valid, one cycle after capture. It falls one cycle after the stall releases.
- There is no combinational path from any output back to PC_src_sel or stall_IF.

## Test plan
- Reset: hold reset 3 cycles, release with PLUS4 and no stall -> PC_PIF=0x200 during reset; PC_IF sequence 0x200, 0x204, 0x208.
- JAL: PC_DX=0x1000, J-imm=+0x40, no stall -> PC_PIF=0x1040 same cycle; PC_IF=0x1040 next cycle.
- Stalled branch: PC_DX=0x300, B-imm=-8, stall_IF=1 for 3 cycles, select back to PLUS4 after the first cycle -> PC_IF holds; redirect_pending=1. On release, PC_PIF=0x2F8, then PC_IF=0x2F8 and redirect_pending=0.
- Supersede: redirect to 0x400 captured under stall, then HANDLER (handler_PC=0x100) still under stall -> after release, PC_IF=0x100 and 0x400 is never fetched.
- JALR alignment: rs1=0x1001, imm=0 -> target 0x1000, no trap. rs1=0x1002, imm=0, ALIGN_LOG2=2 -> PC_IF unchanged; misaligned_fetch pulses 1 cycle; bad_fetch_addr=0x1002.
- Wrap: PC_IF=0xFFFFFFFC with PLUS4 -> PC_IF=0x00000000 with no flag.
